instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the 3-stage RV32I pipeline: owns the PC, issues word fetches to instruction memory over a request/grant/response handshake and delivers the fetched word and its PC through the IF/ID register. Decode and immediate generation read that register directly. The stage honours decode stalls and is redirected by execute on taken branches, JAL and JALR, discarding wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  decode cannot accept; hold IF/ID
- redirect_valid  in  1  execute redirect (taken branch / JAL / JALR)
- redirect_target  in  32  redirect address
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction word
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_instr  out  32  IF/ID instruction; NOP 32'h0000_0013 when invalid
- fetch_misalign  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: BOOT, FETCH, WAIT, HOLD, DRAIN, HALT.
- BOOT: imem_req=0; next cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. Grant -> WAIT; no grant -> stay, request held stable.
- WAIT: imem_req=0. On rvalid: !stall -> IF/ID loads {1, pc, rdata}, pc<=pc+4, -> FETCH. stall -> word and pc go to hold buffer, -> HOLD.
- HOLD: on !stall, buffer moves to IF/ID, pc<=pc+4, -> FETCH.
- DRAIN: one wrong-path response outstanding; next rvalid discarded, -> FETCH.
- At most one request outstanding; rvalid outside WAIT/DRAIN is ignored.
- stall alone: IF/ID unchanged; a new word may still be fetched and parked in HOLD.
- redirect_valid has priority over stall and every state: pc<=target, IF/ID<={0, target, NOP}, hold buffer cleared. Next state:
  - FETCH with gnt same cycle -> DRAIN.
  - FETCH without gnt -> FETCH; address changes to the target next cycle.
  - WAIT with rvalid same cycle -> FETCH; word discarded.
  - WAIT without rvalid -> DRAIN.
  - HOLD, DRAIN -> FETCH. In DRAIN with rvalid same cycle the word is discarded; without rvalid the stale response is still expected, so -> DRAIN.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=RESET_PC, if_id_instr=NOP, fetch_misalign=0, state BOOT, pc=RESET_PC.
- First imem_req is the second cycle after rst_n rises.
- With single-cycle gnt and next-cycle rvalid, IF/ID updates every 2 cycles.
- IF/ID outputs are registered; imem_req and imem_addr decode from state and pc only.
- Redirect: IF/ID shows the bubble the next cycle; target fetch issues the next cycle, or after the drained response.
- rst_n low mid-fetch: every register returns to reset value in one edge; late responses are ignored.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined: redirect with target[1:0]!=0 sets fetch_misalign, invalidates IF/ID and enters HALT (imem_req=0) until reset.
- Undefined: target[1:0] forced to 0, fetch proceeds normally, fetch_misalign tied 0.

## Structure
- Shared riscv_pkg: fetch_state_t enum, NOP_INSTR=32'h0000_0013, XLEN=32.
- Sub-module if_id_reg: valid/pc/instr register with load, stall-hold and flush-to-NOP; the top holds FSM, PC and hold buffer.

## Test plan
- Reset, RESET_PC=32'h100, 1-cycle memory -> imem_addr 100,104,108; IF/ID valid every 2 cycles with matching pc/instr.
- stall high 4 cycles while the 104 response arrives -> IF/ID holds 100, enters HOLD, releases 104 on the cycle after stall drops, no word lost.
- redirect to 32'h200 during WAIT for 108 -> DRAIN discards 108, next request 200, IF/ID shows NOP invalid for the bubble.
- redirect while stall=1 and HOLD -> buffer discarded, next fetch 200, redirect wins.
- imem_gnt low 3 cycles -> imem_req/imem_addr stable until grant.
- redirect to 32'h202: with IFETCH_MISALIGN_CHK_EN fetch_misalign=1 and imem_req stays 0; without it, fetch from 200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: fetch FSM states, NOP encoding, PC helpers.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    FS_BOOT,
    FS_FETCH,
    FS_WAIT,
    FS_HOLD,
    FS_DRAIN,
    FS_HALT
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Where a redirect leaves the fetcher: any request still in flight must be drained.
  function automatic fetch_state_t redirect_next(input fetch_state_t cur,
                                                 input logic         gnt,
                                                 input logic         rvalid);
    case (cur)
      FS_FETCH: return gnt    ? FS_DRAIN : FS_FETCH;
      FS_WAIT:  return rvalid ? FS_FETCH : FS_DRAIN;
      FS_DRAIN: return rvalid ? FS_FETCH : FS_DRAIN;
      default:  return FS_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/grant/response bus between fetch (master) and imem (slave).
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to NOP bubble, load, hold on stall, else drain to bubble.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            stall,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_instr,
  output logic            valid_p1,
  output logic [XLEN-1:0] pc_p1,
  output logic [XLEN-1:0] instr_p1
);

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_p1 <= 1'b0;
      pc_p1    <= RESET_PC;
      instr_p1 <= NOP_INSTR;
    end else if (flush) begin
      valid_p1 <= 1'b0;
      pc_p1    <= d_pc;
      instr_p1 <= NOP_INSTR;
    end else if (load) begin
      valid_p1 <= 1'b1;
      pc_p1    <= d_pc;
      instr_p1 <= d_instr;
    end else if (!stall) begin
      valid_p1 <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, one-outstanding imem fetch FSM, stall hold buffer, redirect drain.
// Optional build macro IFETCH_MISALIGN_CHK_EN halts on a misaligned redirect target.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  instruction_fetch_if.master imem,
  output logic                if_id_valid,
  output logic [XLEN-1:0]     if_id_pc,
  output logic [XLEN-1:0]     if_id_instr,
  output logic                fetch_misalign
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] tgt_eff;
  logic            redirect_take;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_d_pc;
  logic [XLEN-1:0] ifid_d_instr;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misaligned;
  logic misalign_q;
  assign misaligned     = |redirect_target[1:0];
  assign tgt_eff        = redirect_target;
  assign fetch_misalign = misalign_q;
`else
  assign tgt_eff        = redirect_target & WORD_MASK;
  assign fetch_misalign = 1'b0;
`endif

  // A halted fetcher only leaves HALT through reset.
  assign redirect_take  = redirect_valid && (state != FS_HALT);

  assign imem.imem_req  = (state == FS_FETCH);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FS_BOOT;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else if (redirect_take) begin
      pc         <= tgt_eff & WORD_MASK;
      hold_instr <= NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
      if (misaligned) begin
        state      <= FS_HALT;
        misalign_q <= 1'b1;
      end else
`endif
      state <= redirect_next(state, imem.imem_gnt, imem.imem_rvalid);
    end else begin
      case (state)
        FS_BOOT:  state <= FS_FETCH;
        FS_FETCH: if (imem.imem_gnt) state <= FS_WAIT;
        FS_WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              hold_instr <= imem.imem_rdata;
              state      <= FS_HOLD;
            end else begin
              pc    <= pc_inc(pc);
              state <= FS_FETCH;
            end
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            pc         <= pc_inc(pc);
            hold_instr <= NOP_INSTR;
            state      <= FS_FETCH;
          end
        end
        FS_DRAIN: if (imem.imem_rvalid) state <= FS_FETCH;
        FS_HALT:  state <= FS_HALT;
        default:  state <= FS_BOOT;
      endcase
    end
  end

  // A word reaches IF/ID straight from memory or from the hold buffer once decode frees up.
  always_comb begin
    ifid_load    = 1'b0;
    ifid_d_instr = imem.imem_rdata;
    if (!redirect_take && !stall) begin
      if (state == FS_WAIT && imem.imem_rvalid) begin
        ifid_load = 1'b1;
      end else if (state == FS_HOLD) begin
        ifid_load    = 1'b1;
        ifid_d_instr = hold_instr;
      end
    end
  end

  assign ifid_d_pc = redirect_take ? tgt_eff : pc;

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_take),
    .load     (ifid_load),
    .stall    (stall),
    .d_pc     (ifid_d_pc),
    .d_instr  (ifid_d_instr),
    .valid_p1 (if_id_valid),
    .pc_p1    (if_id_pc),
    .instr_p1 (if_id_instr)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed start-up/stall/redirect/wrap cases, then random traffic vs a flag-based model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        fetch_misalign;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (bus),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .fetch_misalign  (fetch_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus knobs (percentages)
  int p_gnt, p_stall, p_redir, p_spur, max_lat;

  // memory responder
  bit          granted;
  logic [31:0] g_addr;
  bit          r_pend;
  int          r_delay;
  logic [31:0] r_addr;
  logic [31:0] glog[$];

  // behavioural model
  bit          model_live;
  bit          m_booted, m_out, m_stale, m_park, m_halt, m_mis;
  logic [31:0] m_pc, m_pword;
  logic        m_v;
  logic [31:0] m_ipc, m_instr;

  bit          seen_v;
  logic [31:0] fv_pc, fv_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFFC;
`ifndef IFETCH_MISALIGN_CHK_EN
    if (r == 1) return 32'h0000_0300 + 32'($urandom_range(0, 255));
`endif
    return 32'h0000_0200 + (32'($urandom_range(0, 63)) << 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          req_m;
    bit          ld;
    logic [31:0] ld_pc, ld_ins;
    if (!rst_n) begin
      m_booted = 0; m_out = 0; m_stale = 0; m_park = 0; m_halt = 0; m_mis = 0;
      m_pc = RST_PC; m_pword = NOP; m_v = 1'b0; m_ipc = RST_PC; m_instr = NOP;
      return;
    end
    req_m = m_booted && !m_out && !m_park && !m_halt;
    ld = 0; ld_pc = '0; ld_ins = '0;
    if (redirect_valid && !m_halt) begin
`ifdef IFETCH_MISALIGN_CHK_EN
      if (redirect_target[1:0] != 2'b00) begin
        m_halt = 1;
        m_mis  = 1;
      end
`endif
      // whatever is still in flight after this edge belongs to the wrong path
      m_out    = (m_out && !bus.imem_rvalid) || (req_m && bus.imem_gnt);
      m_stale  = 1;
      m_park   = 0;
      m_booted = 1;
      m_pc     = {redirect_target[31:2], 2'b00};
      m_v      = 1'b0;
      m_instr  = NOP;
`ifdef IFETCH_MISALIGN_CHK_EN
      m_ipc    = redirect_target;
`else
      m_ipc    = m_pc;
`endif
      return;
    end
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (req_m) begin
      if (bus.imem_gnt) begin
        m_out   = 1;
        m_stale = 0;
      end
    end else if (m_out) begin
      if (bus.imem_rvalid) begin
        m_out = 0;
        if (!m_stale) begin
          if (stall) begin
            m_park  = 1;
            m_pword = bus.imem_rdata;
          end else begin
            ld = 1; ld_pc = m_pc; ld_ins = bus.imem_rdata;
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end else if (m_park && !stall) begin
      ld = 1; ld_pc = m_pc; ld_ins = m_pword;
      m_pc   = m_pc + 32'd4;
      m_park = 0;
    end
    if (ld) begin
      m_v = 1'b1; m_ipc = ld_pc; m_instr = ld_ins;
    end else if (!stall) begin
      m_v = 1'b0; m_instr = NOP;
    end
  endtask

  // One clock: drive inputs just after the rising edge, compare and advance the model at the falling edge.
  task automatic step(input logic rv, input int rd_mode, input logic [31:0] tgt,
                      input int st_mode, input int gn_mode);
    @(posedge clk);
    #1;
    if (granted) begin
      r_pend  = 1;
      r_addr  = g_addr;
      r_delay = $urandom_range(0, max_lat);
    end
    if (r_pend && r_delay == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memf(r_addr);
      r_pend          = 0;
    end else begin
      if (r_pend) r_delay--;
      bus.imem_rvalid = !r_pend && pct(p_spur);
      bus.imem_rdata  = $urandom;
    end
    bus.imem_gnt = (gn_mode < 0) ? pct(p_gnt)   : gn_mode[0];
    stall        = (st_mode < 0) ? pct(p_stall) : st_mode[0];
    if (rd_mode < 0) begin
      redirect_valid  = pct(p_redir);
      redirect_target = rand_target();
    end else begin
      redirect_valid  = rd_mode[0];
      redirect_target = tgt;
    end
    rst_n = rv;
    @(negedge clk);
    granted = bus.imem_req && bus.imem_gnt;
    g_addr  = bus.imem_addr;
    if (granted) glog.push_back(g_addr);
    if (if_id_valid && !seen_v) begin
      seen_v   = 1;
      fv_pc    = if_id_pc;
      fv_instr = if_id_instr;
    end
    if (model_live) begin
      check("imem_req",       {31'd0, bus.imem_req},   {31'd0, m_booted && !m_out && !m_park && !m_halt});
      check("imem_addr",      bus.imem_addr,           m_pc);
      check("if_id_valid",    {31'd0, if_id_valid},    {31'd0, m_v});
      check("if_id_pc",       if_id_pc,                m_ipc);
      check("if_id_instr",    if_id_instr,             m_instr);
      check("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
    end
    model_step();
    model_live = 1;
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (glog.size() < n && k < budget) begin
      step(1'b1, 0, 32'd0, 0, 1);
      k++;
    end
    checks++;
    if (glog.size() < n) begin
      errors++;
      $display("FAIL %s_timeout grants=%0d required=%0d", name, glog.size(), n);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    p_gnt = 100; p_stall = 0; p_redir = 0; p_spur = 0; max_lat = 0;
    granted = 0; g_addr = '0; r_pend = 0; r_delay = 0; r_addr = '0;
    model_live = 0; seen_v = 0; fv_pc = '0; fv_instr = '0;

    repeat (3) step(1'b0, 0, 32'd0, 0, 1);
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr",  bus.imem_addr, 32'h0000_0100);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, 32'h0000_0013);

    step(1'b1, 0, 32'd0, 0, 1);
    check("boot_no_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b1, 0, 32'd0, 0, 1);
    check("first_req",  {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0000_0100);

    wait_grants(3, 20, "seq");
    if (glog.size() >= 3) begin
      check("seq_addr0", glog[0], 32'h0000_0100);
      check("seq_addr1", glog[1], 32'h0000_0104);
      check("seq_addr2", glog[2], 32'h0000_0108);
    end
    check("first_if_id_pc",    fv_pc,    32'h0000_0100);
    check("first_if_id_instr", fv_instr, 32'h0100_FEFF);

    // decode stall across a response, then release
    repeat (4) step(1'b1, 0, 32'd0, 1, 1);
    repeat (6) step(1'b1, 0, 32'd0, 0, 1);

    // grant withheld: request must stay put
    repeat (3) step(1'b1, 0, 32'd0, 0, 0);
    repeat (4) step(1'b1, 0, 32'd0, 0, 1);

    // redirect to the top word: PC must wrap to zero
    glog.delete();
    step(1'b1, 1, 32'hFFFF_FFFC, 0, 0);
    wait_grants(2, 20, "wrap");
    if (glog.size() >= 2) begin
      check("wrap_addr0", glog[0], 32'hFFFF_FFFC);
      check("wrap_addr1", glog[1], 32'h0000_0000);
    end

    // redirect with stall held: parked word must be dropped
    repeat (3) step(1'b1, 0, 32'd0, 1, 1);
    step(1'b1, 1, 32'h0000_0200, 1, 1);
    repeat (6) step(1'b1, 0, 32'd0, 0, 1);

    // misaligned redirect target
    glog.delete();
    step(1'b1, 1, 32'h0000_0202, 0, 0);
`ifdef IFETCH_MISALIGN_CHK_EN
    repeat (4) step(1'b1, 0, 32'd0, 0, 1);
    check("misalign_flag", {31'd0, fetch_misalign}, 32'd1);
    check("misalign_req",  {31'd0, bus.imem_req},   32'd0);
`else
    wait_grants(1, 20, "misalign");
    if (glog.size() >= 1) check("misalign_addr", glog[0], 32'h0000_0200);
    check("misalign_flag", {31'd0, fetch_misalign}, 32'd0);
`endif

    // randomized traffic with a reset in the middle
    p_gnt = 70; p_stall = 25; p_redir = 6; p_spur = 5; max_lat = 2;
    repeat (3) step(1'b0, -1, 32'd0, -1, -1);
    repeat (1500) step(1'b1, -1, 32'd0, -1, -1);
    repeat (3) step(1'b0, -1, 32'd0, -1, -1);
    repeat (1500) step(1'b1, -1, 32'd0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
